xmit_scheduler: RTL and testbench
=================================

Name: xmit_scheduler

Overview:
- Transmit-side scheduler that shares one out_FSM nibble serializer between four frame queues.
- Picks the next queue round-robin and checks the requested frame length.
- Builds the 24-bit control block for out_FSM and holds it under a valid/ready handshake.
- Waits for end-of-frame, then enforces the inter-frame gap before the next grant. Sits between the queue buffers and out_FSM in the Xmit path, in the clk_phy domain.

Parameters:
- LEN_W, 12, width of each frame-length field in bytes.
- MIN_LEN, 64, smallest legal frame length in bytes.
- MAX_LEN, 1518, largest legal frame length in bytes.
- IFG_CYCLES, 24, idle clk_phy cycles between frame_done and the next arbitration (12 bytes × 2 nibbles).

Ports:
- clk_phy  in  1  PHY nibble clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  per-queue frame-pending request; bit i = queue i.
- len_in  in  4*LEN_W  frame length per queue; queue i at [i*LEN_W +: LEN_W].
- ctrl_block_out  out  24  control block to out_FSM: [23:22] qid, [21:20] 2'b00, [19:8] length, [7:0] sequence number.
- ctrl_valid  out  1  ctrl_block_out is valid.
- ctrl_ready  in  1  out_FSM accepts the control block.
- frame_done  in  1  one-cycle pulse from out_FSM after the last nibble of the frame.
- grant  out  4  one-hot, one-cycle pulse: the queue starts streaming data_in.
- reject  out  4  one-hot, one-cycle pulse: the queue must discard its head frame because its length is illegal.
- busy  out  1  high in every state except IDLE.
- frame_seq  out  8  sequence number the next issued frame will carry.
- reject_count  out  8  saturating count of rejected frames.

Behaviour:
- Reset (async assert, sync release): state=IDLE; ctrl_valid=0, ctrl_block_out=0, grant=0, reject=0, busy=0, frame_seq=0, reject_count=0; round-robin pointer=3, so queue 0 has priority first.
- States: IDLE, ISSUE, XMIT, IFG.
- IDLE:
  - If req≠0, search from (ptr+1) mod 4 upward and select the first set bit; latch qid and its length; ptr←qid.
  - Length in [MIN_LEN, MAX_LEN]: go to ISSUE next cycle (ctrl_valid rises 1 cycle after req is sampled).
  - Otherwise: reject[qid]=1 for one cycle, reject_count+1 (holds at 255), stay in IDLE. Next arbitration can start the following cycle.
- ISSUE:
  - ctrl_valid=1; ctrl_block_out stays stable until the cycle where ctrl_valid&&ctrl_ready.
  - In that handshake cycle: grant[qid]=1, frame_seq←frame_seq+1 (wraps 255→0), go to XMIT.
  - The block carries the pre-increment frame_seq.
  - ctrl_valid drops the cycle after the handshake.
  - Once a queue is selected, the request is committed: if req drops during ISSUE the block is still issued.
- XMIT: wait for frame_done; then load the gap counter with IFG_CYCLES-1 and go to IFG.
- IFG:
  - Counter decrements each cycle; at 0 go to IDLE.
  - IDLE is entered IFG_CYCLES cycles after the frame_done cycle; the earliest next ctrl_valid is 1 cycle later.
- frame_done outside XMIT is ignored.
- A frame_done in the same cycle as the handshake is ignored (XMIT not yet entered).
- Only one queue is selected per arbitration; other pending requests wait and are not dropped.
- req bits for queues not selected have no effect until IDLE.
- busy=1 in ISSUE, XMIT and IFG.
- Asynchronous reset mid-frame returns everything to reset values immediately. A frame in flight at out_FSM is not tracked.

Test Plan:
- Reset, req=4'b0001, len0=100, ctrl_ready=1 → ctrl_valid 1 cycle after req, block=0x0_064_00; grant=0001 in the handshake cycle; frame_seq becomes 1.
- All four req high with legal lengths, ctrl_ready=1, frame_done pulsed 10 cycles after each grant → grant order 0,1,2,3,0; sequence numbers 0..4; each new ctrl_valid exactly IFG_CYCLES+1 cycles after frame_done.
- req=0010, len1=40 → reject=0010 for one cycle, reject_count=1, no ctrl_valid. Repeat with len1=1519 → rejected. Repeat with len1=64 and with len1=1518 → both issued.
- ctrl_ready held low for 7 cycles → ctrl_valid and ctrl_block_out stable for all 7 cycles; no grant; req deasserted meanwhile → block still issued when ctrl_ready rises.
- frame_done pulsed in IDLE and during IFG → no state change, IFG length unchanged. 256 frames issued → frame_seq wraps to 0. 300 rejects → reject_count saturates at 255.
- rst_n asserted during XMIT → all outputs 0 immediately; after release, req=1000 → queue 3 served with sequence number 0.

Source files
------------

// File: rtl/xmit_scheduler.sv
// xmit_scheduler: round-robin scheduler sharing one out_FSM between four frame queues.
// Validates frame length, issues a control block under valid/ready, then enforces the inter-frame gap.
module xmit_scheduler #(
    parameter int LEN_W      = 12,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518,
    parameter int IFG_CYCLES = 24
) (
    input  logic               clk_phy,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*LEN_W-1:0] len_in,
    output logic [23:0]        ctrl_block_out,
    output logic               ctrl_valid,
    input  logic               ctrl_ready,
    input  logic               frame_done,
    output logic [3:0]         grant,
    output logic [3:0]         reject,
    output logic               busy,
    output logic [7:0]         frame_seq,
    output logic [7:0]         reject_count
);
    localparam int GW = $clog2(IFG_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, XMIT, IFG} state_t;

    state_t           state, state_d;
    logic [1:0]       ptr, qid, sel, idx;
    logic [LEN_W-1:0] len_q, sel_len;
    logic [GW-1:0]    gap;
    logic             legal;

    // Walk downward so the queue closest after ptr is the last (winning) assignment.
    always_comb begin
        sel = ptr;
        idx = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) sel = idx;
        end
    end

    assign sel_len        = len_in[sel*LEN_W +: LEN_W];
    assign legal          = sel_len >= LEN_W'(MIN_LEN) && sel_len <= LEN_W'(MAX_LEN);
    assign ctrl_valid     = state == ISSUE;
    assign busy           = state != IDLE;
    assign ctrl_block_out = {qid, 2'b00, 12'(len_q), frame_seq};

    always_comb begin
        state_d = state;
        grant   = '0;
        reject  = '0;
        case (state)
            IDLE:
                if (|req) begin
                    if (legal) state_d = ISSUE;
                    else reject = 4'b0001 << sel;
                end
            ISSUE:
                if (ctrl_ready) begin
                    state_d = XMIT;
                    grant   = 4'b0001 << qid;
                end
            XMIT:    state_d = frame_done ? IFG : XMIT;
            default: state_d = gap == '0 ? IDLE : IFG;
        endcase
    end

    always_ff @(posedge clk_phy or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= 2'd3;
            qid          <= '0;
            len_q        <= '0;
            gap          <= '0;
            frame_seq    <= '0;
            reject_count <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && |req) begin
                qid   <= sel;
                ptr   <= sel;
                len_q <= sel_len;
            end
            if (|reject && reject_count != 8'hff) reject_count <= reject_count + 8'd1;
            if (|grant) frame_seq <= frame_seq + 8'd1;
            if (state == XMIT) gap <= GW'(IFG_CYCLES - 1);
            else if (state == IFG) gap <= gap - 1'b1;
        end
    end
endmodule

// File: tb/tb_xmit_scheduler.sv
// tb_xmit_scheduler: directed self-checking bench for xmit_scheduler.
module tb_xmit_scheduler;
    localparam int LEN_W = 12;
    localparam int IFG   = 24;

    logic               clk_phy = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         req = '0;
    logic [4*LEN_W-1:0] len_in = '0;
    logic               ctrl_ready = 1'b0;
    logic               frame_done = 1'b0;
    logic [23:0]        ctrl_block_out;
    logic               ctrl_valid;
    logic [3:0]         grant, reject;
    logic               busy;
    logic [7:0]         frame_seq, reject_count;
    int                 vec = 0;
    int                 errs = 0;

    always #5 clk_phy = ~clk_phy;

    xmit_scheduler #(.LEN_W(LEN_W), .MIN_LEN(64), .MAX_LEN(1518), .IFG_CYCLES(IFG)) dut (
        .clk_phy(clk_phy), .rst_n(rst_n), .req(req), .len_in(len_in),
        .ctrl_block_out(ctrl_block_out), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .frame_done(frame_done), .grant(grant), .reject(reject), .busy(busy),
        .frame_seq(frame_seq), .reject_count(reject_count)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_phy);
        #1;
    endtask

    task automatic set_len(input int q, input int l);
        len_in[q*LEN_W +: LEN_W] = LEN_W'(l);
    endtask

    task automatic reset_dut;
        rst_n = 1'b0; req = '0; ctrl_ready = 1'b0; frame_done = 1'b0; len_in = '0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic finish_frame(output int n);
        frame_done = 1'b1;
        tick;
        frame_done = 1'b0;
        n = 0;
        while (busy && n < 100) begin tick; n++; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = '0; ctrl_ready = 1'b0; frame_done = 1'b0;
        #3;
        vec++; if ({ctrl_valid, ctrl_block_out, grant, reject, busy, frame_seq, reject_count} !== '0) begin
            errs++; $display("FAIL reset_outputs: got valid=%b blk=%h busy=%b seq=%h rc=%h want all 0", ctrl_valid, ctrl_block_out, busy, frame_seq, reject_count);
        end
        tick; rst_n = 1'b1; tick;
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic;
        int n;
        reset_dut;
        set_len(0, 100); ctrl_ready = 1'b1; req = 4'b0001;
        #1;
        vec++; if (ctrl_valid !== 1'b0) begin errs++; $display("FAIL basic_valid_early: got %b want 0", ctrl_valid); end
        tick; req = '0; #1;
        vec++; if (ctrl_valid !== 1'b1) begin errs++; $display("FAIL basic_valid: got %b want 1", ctrl_valid); end
        vec++; if (ctrl_block_out !== 24'h006400) begin errs++; $display("FAIL basic_block: got %h want 006400", ctrl_block_out); end
        vec++; if (grant !== 4'b0001) begin errs++; $display("FAIL basic_grant: got %b want 0001", grant); end
        tick;
        vec++; if (ctrl_valid !== 1'b0) begin errs++; $display("FAIL basic_valid_drop: got %b want 0", ctrl_valid); end
        vec++; if (frame_seq !== 8'd1) begin errs++; $display("FAIL basic_seq: got %0d want 1", frame_seq); end
        vec++; if (grant !== 4'b0000) begin errs++; $display("FAIL basic_grant_pulse: got %b want 0000", grant); end
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy: got %b want 1", busy); end
        finish_frame(n);
        vec++; if (n !== IFG) begin errs++; $display("FAIL basic_ifg: got %0d want %0d", n, IFG); end
    endtask

    task automatic test_round_robin;
        int n, q;
        logic [23:0] exp;
        reset_dut;
        for (int k = 0; k < 4; k++) set_len(k, 100 * (k + 1));
        ctrl_ready = 1'b1; req = 4'hf;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!ctrl_valid && n < 100) begin tick; n++; end
            q = i % 4;
            if (i > 0) begin
                vec++; if (n !== IFG + 1) begin errs++; $display("FAIL rr_gap%0d: got %0d want %0d", i, n, IFG + 1); end
            end
            exp = {2'(q), 2'b00, 12'(100 * (q + 1)), 8'(i)};
            vec++; if (ctrl_block_out !== exp) begin errs++; $display("FAIL rr_block%0d: got %h want %h", i, ctrl_block_out, exp); end
            vec++; if (grant !== 4'b0001 << q) begin errs++; $display("FAIL rr_grant%0d: got %b want q%0d", i, grant, q); end
            tick;
            repeat (9) tick;
            frame_done = 1'b1; tick; frame_done = 1'b0;
        end
        req = '0;
        n = 0;
        while (busy && n < 100) begin tick; n++; end
        vec++; if (n !== IFG) begin errs++; $display("FAIL rr_drain: got %0d want %0d", n, IFG); end
    endtask

    task automatic test_reject;
        int n;
        int bad[2]  = '{40, 1519};
        int good[2] = '{64, 1518};
        reset_dut;
        ctrl_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_len(1, bad[k]); req = 4'b0010; #1;
            vec++; if (reject !== 4'b0010) begin errs++; $display("FAIL rej_pulse%0d: got %b want 0010", k, reject); end
            tick; req = '0; #1;
            vec++; if (reject !== 4'b0000) begin errs++; $display("FAIL rej_clear%0d: got %b want 0000", k, reject); end
            vec++; if (reject_count !== 8'(k + 1)) begin errs++; $display("FAIL rej_count%0d: got %0d want %0d", k, reject_count, k + 1); end
            vec++; if ({ctrl_valid, busy} !== 2'b00) begin errs++; $display("FAIL rej_idle%0d: got valid/busy %b want 00", k, {ctrl_valid, busy}); end
        end
        for (int k = 0; k < 2; k++) begin
            set_len(1, good[k]); req = 4'b0010; #1;
            vec++; if (reject !== 4'b0000) begin errs++; $display("FAIL legal_noreject%0d: got %b want 0000", k, reject); end
            tick; req = '0; #1;
            vec++; if (ctrl_valid !== 1'b1) begin errs++; $display("FAIL legal_valid%0d: got %b want 1", k, ctrl_valid); end
            vec++; if (ctrl_block_out[19:8] !== 12'(good[k])) begin errs++; $display("FAIL legal_len%0d: got %0d want %0d", k, ctrl_block_out[19:8], good[k]); end
            vec++; if (grant !== 4'b0010) begin errs++; $display("FAIL legal_grant%0d: got %b want 0010", k, grant); end
            tick;
            finish_frame(n);
            vec++; if (n !== IFG) begin errs++; $display("FAIL legal_ifg%0d: got %0d want %0d", k, n, IFG); end
        end
        vec++; if (reject_count !== 8'd2) begin errs++; $display("FAIL legal_rc: got %0d want 2", reject_count); end
    endtask

    task automatic test_stall;
        int n;
        reset_dut;
        set_len(2, 500); req = 4'b0100;
        tick; req = '0; #1;
        for (int i = 0; i < 7; i++) begin
            vec++; if ({ctrl_valid, ctrl_block_out, grant} !== {1'b1, 24'h81F400, 4'b0000}) begin
                errs++; $display("FAIL stall%0d: got valid=%b blk=%h grant=%b want 1 81f400 0000", i, ctrl_valid, ctrl_block_out, grant);
            end
            tick;
        end
        ctrl_ready = 1'b1; #1;
        vec++; if (grant !== 4'b0100) begin errs++; $display("FAIL stall_grant: got %b want 0100", grant); end
        tick;
        vec++; if ({ctrl_valid, frame_seq} !== {1'b0, 8'd1}) begin errs++; $display("FAIL stall_after: got valid=%b seq=%0d want 0 1", ctrl_valid, frame_seq); end
        finish_frame(n);
        vec++; if (n !== IFG) begin errs++; $display("FAIL stall_ifg: got %0d want %0d", n, IFG); end
    endtask

    task automatic test_frame_done_ignored;
        int n;
        reset_dut;
        ctrl_ready = 1'b1;
        frame_done = 1'b1; tick; frame_done = 1'b0;
        vec++; if ({busy, ctrl_valid} !== 2'b00) begin errs++; $display("FAIL fd_idle: got busy/valid %b want 00", {busy, ctrl_valid}); end
        set_len(0, 100); req = 4'b0001;
        tick; req = '0; frame_done = 1'b1; #1;
        vec++; if (grant !== 4'b0001) begin errs++; $display("FAIL fd_hs_grant: got %b want 0001", grant); end
        tick; frame_done = 1'b0;
        repeat (30) tick;
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL fd_handshake_ignored: got busy %b want 1", busy); end
        frame_done = 1'b1; tick; frame_done = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            if (n == 5 || n == 12) frame_done = 1'b1;
            tick; frame_done = 1'b0; n++;
        end
        vec++; if (n !== IFG) begin errs++; $display("FAIL fd_ifg: got %0d want %0d", n, IFG); end
    endtask

    task automatic test_seq_wrap;
        int n;
        reset_dut;
        ctrl_ready = 1'b1; set_len(0, 100);
        for (int i = 0; i < 256; i++) begin
            req = 4'b0001;
            tick; req = '0; #1;
            vec++; if ({ctrl_valid, ctrl_block_out[7:0]} !== {1'b1, 8'(i)}) begin
                errs++; $display("FAIL wrap_seq%0d: got valid=%b seq=%0d want 1 %0d", i, ctrl_valid, ctrl_block_out[7:0], i);
            end
            tick;
            finish_frame(n);
            vec++; if (n !== IFG) begin errs++; $display("FAIL wrap_ifg%0d: got %0d want %0d", i, n, IFG); end
        end
        vec++; if (frame_seq !== 8'd0) begin errs++; $display("FAIL wrap_final: got %0d want 0", frame_seq); end
    endtask

    task automatic test_reject_sat;
        int exp;
        reset_dut;
        set_len(0, 10); req = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            tick;
            exp = i < 254 ? i + 1 : 255;
            if (i == 253 || i == 254 || i == 299) begin
                vec++; if (reject_count !== 8'(exp)) begin errs++; $display("FAIL sat%0d: got %0d want %0d", i, reject_count, exp); end
            end
        end
        req = '0;
        vec++; if (ctrl_valid !== 1'b0) begin errs++; $display("FAIL sat_valid: got %b want 0", ctrl_valid); end
    endtask

    task automatic test_async_reset;
        int n;
        reset_dut;
        set_len(0, 10); req = 4'b0001;
        tick; req = '0;
        set_len(0, 100); ctrl_ready = 1'b1; req = 4'b0001;
        tick; req = '0;
        tick;
        vec++; if ({busy, reject_count, frame_seq} !== {1'b1, 8'd1, 8'd1}) begin
            errs++; $display("FAIL ar_pre: got busy=%b rc=%0d seq=%0d want 1 1 1", busy, reject_count, frame_seq);
        end
        #2 rst_n = 1'b0;
        #1;
        vec++; if ({ctrl_valid, ctrl_block_out, grant, reject, busy, frame_seq, reject_count} !== '0) begin
            errs++; $display("FAIL ar_clear: got valid=%b blk=%h busy=%b seq=%0d rc=%0d want all 0", ctrl_valid, ctrl_block_out, busy, frame_seq, reject_count);
        end
        @(negedge clk_phy);
        rst_n = 1'b1; set_len(3, 200); req = 4'b1000;
        tick; req = '0; #1;
        vec++; if (ctrl_block_out !== 24'hC0C800) begin errs++; $display("FAIL ar_block: got %h want c0c800", ctrl_block_out); end
        vec++; if (grant !== 4'b1000) begin errs++; $display("FAIL ar_grant: got %b want 1000", grant); end
        tick;
        finish_frame(n);
        vec++; if (n !== IFG) begin errs++; $display("FAIL ar_ifg: got %0d want %0d", n, IFG); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_round_robin;
        test_reject;
        test_stall;
        test_frame_done_ignored;
        test_seq_wrap;
        test_reject_sat;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
